data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Data-memory controller on the core's load/store port: consumes the core's `mem_in_s` request plus byte address, and produces the `mem_out_s` acceptance/response handshake. It sits directly downstream of the core's memory stage. It serves one outstanding request at a time with a fixed, parameterised latency. Byte stores and loads (SB/LBU) and word stores and loads (SW/LW) are handled on a little-endian 32-bit word array.

## Interface
- `addr_width_p`, default 10: number of word-address bits; storage is 2^addr_width_p × 32 bits.
- `latency_p`, default 2: cycles from acceptance to response valid; legal range is ≥1.
- `clk`, input, 1: the single clock.
- `reset`, input, 1: synchronous, active-high reset.
- `to_mem_i`, input, `mem_in_s`: request from the core.
  - Fields: `write_data`, `valid`, `wen`, `byte_not_word`, `yumi`.
  - `yumi` is the core's acknowledgement of a response.
- `addr_i`, input, 32: byte address, sampled with the request.
- `from_mem_o`, output, `mem_out_s`: handshake back to the core.
  - `yumi` accepts a request.
  - `valid` and `read_data` carry the response.
- `misalign_o`, output, 1: sticky misaligned-access flag; present only with `DMEM_MISALIGN_EXC_EN`.

## Operation
- State machine `dmem_state_e` has three states: IDLE, BUSY, RESP. Reset state is IDLE.
- IDLE:
  - `from_mem_o.yumi` = `to_mem_i.valid` (combinational).
  - On valid, register `addr_i`, `write_data`, `wen` and `byte_not_word`. Load the latency counter with `latency_p`-1.
  - If `latency_p`==1, go directly to RESP. Otherwise go to BUSY.
- BUSY: decrement the counter each cycle. When the counter is 0, go to RESP.
- Commit on the BUSY/IDLE→RESP transition edge:
  - Word store: writes `mem[word]` = `write_data`.
  - Byte store: writes only lane `addr[1:0]` with `write_data[7:0]`.
  - Loads: register `read_data`.
    - Word load: the full word.
    - Byte load: `{24'b0, lane byte}`.
  - Stores: `read_data` = 32'b0.
- RESP: `from_mem_o.valid`=1, with `read_data` held stable. Stay in RESP until `to_mem_i.yumi`, then go to IDLE.
- Word index is `addr_i[addr_width_p+1:2]`. Higher address bits are ignored, so the address wraps modulo the array size.
- `to_mem_i.valid` is ignored outside IDLE, and `from_mem_o.yumi`=0 there.
- Simultaneous yumi and new valid in RESP: the new request is not accepted that cycle. It is accepted in the following IDLE cycle.
- Reset in BUSY or RESP: return to IDLE and drop the pending request. A store still in BUSY is never written. Array contents are not reset.
- Reset values: `from_mem_o.valid`=0, `from_mem_o.read_data`=0, `misalign_o`=0. `from_mem_o.yumi`=0 while `reset` is high.

## Timing
- Request accepted in cycle T (valid and yumi both high) → `from_mem_o.valid` rises in cycle T+`latency_p`.
- Response is acknowledged in cycle R → `valid` falls at R+1.
- The earliest next acceptance is R+1.
- Minimum request-to-request spacing is `latency_p`+1 cycles.
- `from_mem_o.yumi` is a combinational path from `to_mem_i.valid`. It has no dependency on `to_mem_i.yumi`.
- Read data reflects every store committed before the acceptance of the load.

## Configuration
- `DMEM_MISALIGN_EXC_EN` defined:
  - A word request with `addr_i[1:0]`≠0 sets `misalign_o` (sticky until reset).
  - The request is still accepted and responded to.
  - A misaligned store is not written.
  - A misaligned load returns 32'b0.
- Macro undefined:
  - The `misalign_o` port is absent.
  - Low address bits are ignored for word accesses, which act on the aligned word.

## Structure
- Add `dmem_state_e` (IDLE/BUSY/RESP) to the shared definitions package, next to `mem_in_s` and `mem_out_s`.
- The latency counter width is `$clog2(latency_p)`+1.
- One sub-module, `dmem_ram`: synchronous single-port word array.
  - Per-byte write enables (4 bits).
  - Combinational read of the addressed word.
- The controller performs lane select and zero-extension.

## Test plan
- Word SW then LW: SW `addr` 0x10, data 0xDEADBEEF → yumi in the accept cycle, valid at T+2 with read_data 0; LW 0x10 → read_data 0xDEADBEEF.
- SB to `addr` 0x13 with data 0x000000AA over a word of 0x11223344 → LW 0x10 returns 0xAA223344. LBU 0x13 returns 0x000000AA.
- Response hold: the core withholds yumi for 5 cycles → valid and read_data are stable for all 5 cycles. A new valid held during RESP is not accepted until the cycle after yumi.
- Reset asserted while a SW to 0x20 (data 0x5) is in BUSY → state is IDLE next cycle and valid=0. A later LW 0x20 returns the pre-store contents.
- `latency_p`=1 and address wrap: accept at T, valid at T+1. With `addr_width_p`=10, SW at 0x1000 then LW at 0x0 → data matches.
- With `DMEM_MISALIGN_EXC_EN`: LW at 0x12 → `misalign_o`=1, read_data 0, and the flag holds until reset.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared load/store port types for the data-memory controller: request/response
// structs, controller state encoding and byte-lane helpers.
package data_mem_ctrl_pkg;

    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic        yumi;
        logic        valid;
        logic [31:0] read_data;
    } mem_out_s;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/data_mem_ctrl_dmem_ram.sv
// Single-port 32-bit word array: synchronous per-byte write, combinational read.
// Contents are deliberately never reset.
module dmem_ram
    import data_mem_ctrl_pkg::*;
#(
    parameter int addr_width_p = 10
) (
    input  logic                    clk,
    input  logic [3:0]              i_be,
    input  logic [addr_width_p-1:0] i_addr,
    input  logic [31:0]             i_wdata,
    output logic [31:0]             o_rdata
);

    logic [31:0] r_mem [2**addr_width_p];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_be[b]) begin
                r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: one outstanding SB/SW/LBU/LW request, fixed latency_p.
// Optional DMEM_MISALIGN_EXC_EN adds the sticky misalign_o flag and suppresses misaligned word accesses.
//
//   state | meaning
//   IDLE  | ready; from_mem_o.yumi follows to_mem_i.valid
//   BUSY  | request captured, latency counter running
//   RESP  | response valid, waiting for to_mem_i.yumi
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  mem_in_s     to_mem_i,
    input  logic [31:0] addr_i,
    output mem_out_s    from_mem_o
`ifdef DMEM_MISALIGN_EXC_EN
    ,
    output logic        misalign_o
`endif
);

    localparam int                  cnt_w_lp    = $clog2(latency_p) + 1;
    localparam logic [cnt_w_lp-1:0] cnt_load_lp = cnt_w_lp'(latency_p - 1);
`ifdef DMEM_MISALIGN_EXC_EN
    localparam logic misalign_en_lp = 1'b1;
`else
    localparam logic misalign_en_lp = 1'b0;
`endif

    dmem_state_e              r_state;
    logic [cnt_w_lp-1:0]      r_cnt;
    logic [addr_width_p-1:0]  r_word;
    logic [1:0]               r_lane;
    logic [31:0]              r_wdata;
    logic                     r_wen;
    logic                     r_bnw;
    logic                     r_valid;
    logic [31:0]              r_read_data;

    logic                     w_idle;
    logic                     w_accept;
    logic                     w_commit;
    logic [cnt_w_lp-1:0]      w_cnt_dec;
    logic [addr_width_p-1:0]  w_cur_word;
    logic [1:0]               w_cur_lane;
    logic [31:0]              w_cur_wdata;
    logic                     w_cur_wen;
    logic                     w_cur_bnw;
    logic                     w_cur_bad;
    logic [3:0]               w_be;
    logic [31:0]              w_ram_wdata;
    logic [31:0]              w_rdata;
    logic [31:0]              w_load_data;
    logic                     w_unused_addr_hi;

    assign w_unused_addr_hi = ^addr_i[31:addr_width_p+2];

    assign w_idle    = (r_state == IDLE);
    assign w_accept  = w_idle & to_mem_i.valid & ~reset;
    assign w_cnt_dec = r_cnt - 1'b1;
    assign w_commit  = ~reset & ((w_accept & (latency_p == 1))
                               | ((r_state == BUSY) & (w_cnt_dec == '0)));

    // With latency_p==1 the commit edge is the accept edge, so act on the live request.
    assign w_cur_word  = w_idle ? addr_i[addr_width_p+1:2]  : r_word;
    assign w_cur_lane  = w_idle ? addr_i[1:0]               : r_lane;
    assign w_cur_wdata = w_idle ? to_mem_i.write_data       : r_wdata;
    assign w_cur_wen   = w_idle ? to_mem_i.wen              : r_wen;
    assign w_cur_bnw   = w_idle ? to_mem_i.byte_not_word    : r_bnw;
    assign w_cur_bad   = misalign_en_lp & ~w_cur_bnw & (w_cur_lane != 2'b00);

    always_comb begin
        w_be = 4'b0000;
        if (w_commit && w_cur_wen && !w_cur_bad) begin
            w_be = w_cur_bnw ? lane_mask(w_cur_lane) : 4'b1111;
        end
    end

    assign w_ram_wdata = w_cur_bnw ? {4{w_cur_wdata[7:0]}} : w_cur_wdata;

    always_comb begin
        w_load_data = 32'b0;
        if (!w_cur_wen && !w_cur_bad) begin
            w_load_data = w_cur_bnw ? {24'b0, lane_byte(w_rdata, w_cur_lane)} : w_rdata;
        end
    end

    dmem_ram #(
        .addr_width_p(addr_width_p)
    ) u_ram (
        .clk     (clk),
        .i_be    (w_be),
        .i_addr  (w_cur_word),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_valid     <= 1'b0;
            r_read_data <= 32'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (to_mem_i.valid) begin
                        r_word  <= addr_i[addr_width_p+1:2];
                        r_lane  <= addr_i[1:0];
                        r_wdata <= to_mem_i.write_data;
                        r_wen   <= to_mem_i.wen;
                        r_bnw   <= to_mem_i.byte_not_word;
                        r_cnt   <= cnt_load_lp;
                        r_state <= (latency_p == 1) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    r_cnt <= w_cnt_dec;
                    if (w_cnt_dec == '0) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (to_mem_i.yumi) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_commit) begin
                r_valid     <= 1'b1;
                r_read_data <= w_load_data;
            end
        end
    end

`ifdef DMEM_MISALIGN_EXC_EN
    logic r_misalign;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else if (w_accept && w_cur_bad) begin
            r_misalign <= 1'b1;
        end
    end

    assign misalign_o = r_misalign;
`endif

    assign from_mem_o = '{yumi: w_accept, valid: r_valid, read_data: r_read_data};

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: a latency-2 instance and a latency-1 instance
// share one request driver; expected read data is queued at acceptance and compared at response.
module tb_data_mem_ctrl;
    import data_mem_ctrl_pkg::*;

    typedef struct {
        bit          wen;
        bit          bnw;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } op_t;

    logic        clk = 1'b0;
    logic        reset;
    mem_in_s     req;
    mem_in_s     in0;
    mem_in_s     in1;
    logic [31:0] addr;
    mem_out_s    out0;
    mem_out_s    out1;
    mem_out_s    mon;
    bit          sel;
`ifdef DMEM_MISALIGN_EXC_EN
    logic        mis0;
    logic        mis1;
`endif

    int          cycle = 0;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    always_comb begin
        in0 = req;
        in1 = req;
        if (sel) begin
            in0.valid = 1'b0;
            in0.yumi  = 1'b0;
        end else begin
            in1.valid = 1'b0;
            in1.yumi  = 1'b0;
        end
    end

    assign mon = sel ? out1 : out0;

    data_mem_ctrl #(.addr_width_p(10), .latency_p(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .to_mem_i   (in0),
        .addr_i     (addr),
        .from_mem_o (out0)
`ifdef DMEM_MISALIGN_EXC_EN
        ,
        .misalign_o (mis0)
`endif
    );

    data_mem_ctrl #(.addr_width_p(10), .latency_p(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .to_mem_i   (in1),
        .addr_i     (addr),
        .from_mem_o (out1)
`ifdef DMEM_MISALIGN_EXC_EN
        ,
        .misalign_o (mis1)
`endif
    );

    task automatic send(input bit wen, input bit bnw, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp, output int acc, output bit ok);
        ok  = 1'b0;
        acc = -1;
        @(posedge clk); #1;
        req.valid = 1'b1; req.wen = wen; req.byte_not_word = bnw; req.write_data = d; addr = a;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mon.yumi === 1'b1) begin
                ok  = 1'b1;
                acc = cycle;
                break;
            end
        end
        @(posedge clk); #1;
        req.valid = 1'b0;
        if (ok) sb.push_back(exp);
    endtask

    task automatic wait_resp(input int acc, output logic [31:0] rd, output int lat, output bit ok);
        ok  = 1'b0;
        lat = -1;
        rd  = 'x;
        for (int i = 0; i < 20; i++) begin
            if (mon.valid === 1'b1) begin
                ok  = 1'b1;
                lat = cycle - acc;
                rd  = mon.read_data;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic ack();
        req.yumi = 1'b1;
        @(posedge clk); #1;
        req.yumi = 1'b0;
    endtask

    task automatic xact(input bit wen, input bit bnw, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp, output logic [31:0] rd, output int lat, output bit ok);
        int acc;
        bit ok1;
        rd  = 'x;
        lat = -1;
        send(wen, bnw, a, d, exp, acc, ok1);
        if (!ok1) begin
            ok = 1'b0;
            return;
        end
        wait_resp(acc, rd, lat, ok);
        if (ok) ack();
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; addr = '0; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1 req.valid = 1'b1;
        @(negedge clk);
        total++; if (out0.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", out0.valid); end
        total++; if (out0.read_data !== 32'h0) begin bad++; $display("FAIL reset_rdata got %h want 0", out0.read_data); end
        total++; if (out0.yumi !== 1'b0) begin bad++; $display("FAIL reset_yumi got %b want 0", out0.yumi); end
        total++; if (out1.valid !== 1'b0) begin bad++; $display("FAIL reset_valid_l1 got %b want 0", out1.valid); end
`ifdef DMEM_MISALIGN_EXC_EN
        total++; if (mis0 !== 1'b0) begin bad++; $display("FAIL reset_misalign got %b want 0", mis0); end
`endif
        req.valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_word();
        op_t ops[$];
        logic [31:0] rd, exp;
        int lat;
        bit ok;
        ops.push_back('{1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0});
        ops.push_back('{1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF});
        foreach (ops[i]) begin
            xact(ops[i].wen, ops[i].bnw, ops[i].a, ops[i].d, ops[i].exp, rd, lat, ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL word[%0d] no response got none want valid", i); sb.delete();
            end else begin
                exp = sb.pop_front();
                if (rd !== exp) begin bad++; $display("FAIL word[%0d] read_data got %h want %h", i, rd, exp); end
                total++;
                if (lat !== 2) begin bad++; $display("FAIL word[%0d] latency got %0d want 2", i, lat); end
                total++;
                if (mon.valid !== 1'b0) begin bad++; $display("FAIL word[%0d] valid after ack got %b want 0", i, mon.valid); end
            end
        end
    endtask

    task automatic test_byte();
        op_t ops[$];
        logic [31:0] rd, exp;
        int lat;
        bit ok;
        ops.push_back('{1'b1, 1'b0, 32'h10, 32'h11223344, 32'h0});
        ops.push_back('{1'b1, 1'b1, 32'h13, 32'h000000AA, 32'h0});
        ops.push_back('{1'b0, 1'b0, 32'h10, 32'h0, 32'hAA223344});
        ops.push_back('{1'b0, 1'b1, 32'h13, 32'h0, 32'h000000AA});
        ops.push_back('{1'b0, 1'b1, 32'h11, 32'h0, 32'h00000033});
        ops.push_back('{1'b0, 1'b1, 32'h10, 32'h0, 32'h00000044});
        ops.push_back('{1'b1, 1'b1, 32'h11, 32'hFFFFFF55, 32'h0});
        ops.push_back('{1'b0, 1'b0, 32'h10, 32'h0, 32'hAA225544});
        foreach (ops[i]) begin
            xact(ops[i].wen, ops[i].bnw, ops[i].a, ops[i].d, ops[i].exp, rd, lat, ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL byte[%0d] no response got none want valid", i); sb.delete();
            end else begin
                exp = sb.pop_front();
                if (rd !== exp) begin bad++; $display("FAIL byte[%0d] read_data got %h want %h", i, rd, exp); end
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] rd, rd0, exp;
        int lat, acc;
        bit ok;
        bit stable;
        bit blocked;
        xact(1'b1, 1'b0, 32'h14, 32'h600DF00D, 32'h0, rd, lat, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL hold_setup no response got none want valid"); sb.delete(); return; end
        exp = sb.pop_front();
        if (rd !== exp) begin bad++; $display("FAIL hold_setup read_data got %h want %h", rd, exp); end
        send(1'b0, 1'b0, 32'h14, 32'h0, 32'h600DF00D, acc, ok);
        if (ok) wait_resp(acc, rd0, lat, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL hold_load no response got none want valid"); sb.delete(); return; end
        exp = sb.pop_front();
        if (rd0 !== exp) begin bad++; $display("FAIL hold_load read_data got %h want %h", rd0, exp); end
        req.valid = 1'b1; req.wen = 1'b0; req.byte_not_word = 1'b0; addr = 32'h10;
        stable  = 1'b1;
        blocked = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (mon.valid !== 1'b1 || mon.read_data !== rd0) stable = 1'b0;
            if (mon.yumi !== 1'b0) blocked = 1'b0;
            @(negedge clk);
        end
        total++; if (!stable) begin bad++; $display("FAIL hold_stable got changed want %h held", rd0); end
        total++; if (!blocked) begin bad++; $display("FAIL hold_no_accept got yumi=1 want 0 in RESP"); end
        req.yumi = 1'b1;
        #1;
        total++; if (mon.yumi !== 1'b0) begin bad++; $display("FAIL hold_ack_cycle yumi got %b want 0", mon.yumi); end
        @(posedge clk); #1;
        req.yumi = 1'b0;
        total++; if (mon.valid !== 1'b0) begin bad++; $display("FAIL hold_drop valid got %b want 0", mon.valid); end
        total++; if (mon.yumi !== 1'b1) begin bad++; $display("FAIL hold_next_accept yumi got %b want 1", mon.yumi); end
        acc = cycle;
        sb.push_back(32'hAA225544);
        @(posedge clk); #1;
        req.valid = 1'b0;
        wait_resp(acc, rd, lat, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL hold_followup no response got none want valid"); sb.delete(); return; end
        ack();
        exp = sb.pop_front();
        if (rd !== exp) begin bad++; $display("FAIL hold_followup read_data got %h want %h", rd, exp); end
        total++; if (lat !== 2) begin bad++; $display("FAIL hold_followup latency got %0d want 2", lat); end
    endtask

    task automatic test_reset_busy();
        logic [31:0] rd, exp;
        int lat, acc;
        bit ok;
        bit quiet;
        xact(1'b1, 1'b0, 32'h20, 32'h00000077, 32'h0, rd, lat, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rst_setup no response got none want valid"); sb.delete(); return; end
        exp = sb.pop_front();
        if (rd !== exp) begin bad++; $display("FAIL rst_setup read_data got %h want %h", rd, exp); end
        send(1'b1, 1'b0, 32'h20, 32'h00000005, 32'h0, acc, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rst_accept got no yumi want yumi"); return; end
        void'(sb.pop_back());
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if (mon.valid !== 1'b0) begin bad++; $display("FAIL rst_busy valid got %b want 0", mon.valid); end
        quiet = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mon.valid !== 1'b0) quiet = 1'b0;
        end
        total++; if (!quiet) begin bad++; $display("FAIL rst_dropped got valid=1 want 0"); end
        xact(1'b0, 1'b0, 32'h20, 32'h0, 32'h00000077, rd, lat, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rst_readback no response got none want valid"); sb.delete(); return; end
        exp = sb.pop_front();
        if (rd !== exp) begin bad++; $display("FAIL rst_readback read_data got %h want %h", rd, exp); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd, exp;
        int lat;
        bit ok;
        xact(1'b1, 1'b0, 32'h1000, 32'hCAFEF00D, 32'h0, rd, lat, ok);
        if (ok) begin
            void'(sb.pop_front());
            xact(1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, rd, lat, ok);
        end
        total++;
        if (!ok) begin bad++; $display("FAIL wrap no response got none want valid"); sb.delete(); return; end
        exp = sb.pop_front();
        if (rd !== exp) begin bad++; $display("FAIL wrap read_data got %h want %h", rd, exp); end
    endtask

    task automatic test_latency1();
        op_t ops[$];
        logic [31:0] rd, exp;
        int lat;
        bit ok;
        sel = 1'b1;
        ops.push_back('{1'b1, 1'b0, 32'h1000, 32'h12345678, 32'h0});
        ops.push_back('{1'b0, 1'b0, 32'h0, 32'h0, 32'h12345678});
        ops.push_back('{1'b1, 1'b1, 32'h2, 32'h000000EE, 32'h0});
        ops.push_back('{1'b0, 1'b0, 32'h0, 32'h0, 32'h12EE5678});
        foreach (ops[i]) begin
            xact(ops[i].wen, ops[i].bnw, ops[i].a, ops[i].d, ops[i].exp, rd, lat, ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL lat1[%0d] no response got none want valid", i); sb.delete();
            end else begin
                exp = sb.pop_front();
                if (rd !== exp) begin bad++; $display("FAIL lat1[%0d] read_data got %h want %h", i, rd, exp); end
                total++;
                if (lat !== 1) begin bad++; $display("FAIL lat1[%0d] latency got %0d want 1", i, lat); end
                total++;
                if (mon.valid !== 1'b0) begin bad++; $display("FAIL lat1[%0d] valid after ack got %b want 0", i, mon.valid); end
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_misalign();
        op_t ops[$];
        logic [31:0] rd, exp;
        int lat;
        bit ok;
`ifdef DMEM_MISALIGN_EXC_EN
        ops.push_back('{1'b0, 1'b0, 32'h12, 32'h0, 32'h0});
        ops.push_back('{1'b1, 1'b0, 32'h16, 32'h11111111, 32'h0});
        ops.push_back('{1'b0, 1'b0, 32'h14, 32'h0, 32'h600DF00D});
`else
        ops.push_back('{1'b0, 1'b0, 32'h12, 32'h0, 32'hAA225544});
        ops.push_back('{1'b1, 1'b0, 32'h16, 32'h0F0F0F0F, 32'h0});
        ops.push_back('{1'b0, 1'b0, 32'h14, 32'h0, 32'h0F0F0F0F});
`endif
        foreach (ops[i]) begin
            xact(ops[i].wen, ops[i].bnw, ops[i].a, ops[i].d, ops[i].exp, rd, lat, ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL misalign[%0d] no response got none want valid", i); sb.delete();
            end else begin
                exp = sb.pop_front();
                if (rd !== exp) begin bad++; $display("FAIL misalign[%0d] read_data got %h want %h", i, rd, exp); end
            end
`ifdef DMEM_MISALIGN_EXC_EN
            total++;
            if (mis0 !== 1'b1) begin bad++; $display("FAIL misalign_flag[%0d] got %b want 1", i, mis0); end
`endif
        end
`ifdef DMEM_MISALIGN_EXC_EN
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if (mis0 !== 1'b0) begin bad++; $display("FAIL misalign_clear got %b want 0", mis0); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_hold();
        test_reset_busy();
        test_wrap();
        test_latency1();
        test_misalign();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
